// File: rtl/fc_layer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fc_layer_seq
// Description : Sequential fully-connected layer. One MAC per cycle over an
//               N_IN-element signed vector for each of N_OUT neurons. Each
//               neuron gets a bias, an arithmetic shift, optional ReLU and
//               saturation to OUT_W. Results stream out under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_seq #(
    parameter  int N_IN  = 9,
    parameter  int N_OUT = 4,
    parameter  int DW    = 8,
    parameter  int ACC_W = 32,
    parameter  int OUT_W = 16,
    parameter  int SHIFT = 0,
    localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_wr_en,
    input  logic [WA_W-1:0]         w_addr,
    input  logic signed [DW-1:0]    w_data,
    input  logic                    b_wr_en,
    input  logic [JW-1:0]           b_addr,
    input  logic signed [ACC_W-1:0] b_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*DW-1:0]      in_data,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [JW-1:0]           out_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int W_DEPTH = N_IN * N_OUT;
    localparam int IW      = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [WA_W:0] W_DEPTH_V = (WA_W + 1)'(W_DEPTH);
    localparam logic [JW:0]   B_DEPTH_V = (JW + 1)'(N_OUT);
    localparam logic [IW-1:0] I_LAST    = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST    = JW'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [DW-1:0]    x_q [N_IN];
    logic signed [DW-1:0]    x_d [N_IN];
    logic                    relu_q, relu_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic [JW-1:0]           out_idx_q, out_idx_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Coefficient storage: no reset, contents undefined until written.
    logic signed [DW-1:0]    weight_mem [W_DEPTH];
    logic signed [ACC_W-1:0] bias_mem   [N_OUT];

    logic [WA_W-1:0]         mac_addr;
    logic signed [DW-1:0]    mac_w;
    logic signed [2*DW-1:0]  mac_prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] res_shift;
    logic signed [OUT_W-1:0] res_sat;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // MAC datapath and post-processing of the running sum (shift, ReLU, clamp).
    always_comb begin
        mac_addr  = WA_W'(j_q) * WA_W'(N_IN) + WA_W'(i_q);
        mac_w     = weight_mem[mac_addr];
        mac_prod  = (2 * DW)'(x_q[i_q]) * (2 * DW)'(mac_w);
        acc_sum   = acc_q + ACC_W'(mac_prod);
        res_shift = acc_sum >>> SHIFT;
        if (relu_q && res_shift[ACC_W-1]) begin
            res_shift = '0;
        end
        if (res_shift > SAT_MAX) begin
            res_sat = SAT_MAX[OUT_W-1:0];
        end else if (res_shift < SAT_MIN) begin
            res_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            res_sat = res_shift[OUT_W-1:0];
        end
    end

    // Next-state logic for the IDLE -> MAC -> OUT sequencer and its outputs.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        relu_d      = relu_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < N_IN; k++) begin
                        x_d[k] = in_data[k*DW +: DW];
                    end
                    relu_d  = relu_en;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = bias_mem[0];
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                if (i_q == I_LAST) begin
                    // The result is registered from the sum including the last term.
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = res_sat;
                    out_idx_d   = j_q;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (j_q == J_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        j_d     = j_q + JW'(1);
                        i_d     = '0;
                        acc_d   = bias_mem[j_q + JW'(1)];
                        state_d = ST_MAC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            relu_q      <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            relu_q      <= relu_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Latched input vector; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
    end

    // Coefficient writes, honoured only while idle and in range.
    always_ff @(posedge clk) begin
        if (w_wr_en && (state_q == ST_IDLE) && ({1'b0, w_addr} < W_DEPTH_V)) begin
            weight_mem[w_addr] <= w_data;
        end
        if (b_wr_en && (state_q == ST_IDLE) && ({1'b0, b_addr} < B_DEPTH_V)) begin
            bias_mem[b_addr] <= b_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fc_layer_seq
// Description : Scoreboard bench for fc_layer_seq. Two instances share all
//               stimulus: SHIFT=0 and SHIFT=2, each with its own queue of
//               hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_seq;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_wr_en;
    logic [5:0]  w_addr;
    logic [7:0]  w_data;
    logic        b_wr_en;
    logic [1:0]  b_addr;
    logic [31:0] b_data;
    logic        in_valid;
    logic [71:0] in_data;
    logic        relu_en;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0, done0;
    logic [15:0] out_data0;
    logic [1:0]  out_idx0;
    logic        in_ready1, out_valid1, busy1, done1;
    logic [15:0] out_data1;
    logic [1:0]  out_idx1;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    bit   first_pend = 0;
    bit   chk_lat = 0;
    int   exp_done_lat = 41;
    bit   lat_on = 0;
    int   lat_done = 41;
    int   exp_dones = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_seq #(.N_IN(9), .N_OUT(4), .DW(8), .ACC_W(32), .OUT_W(16), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .relu_en(relu_en),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_idx(out_idx0),
        .busy(busy0), .done(done0)
    );

    fc_layer_seq #(.N_IN(9), .N_OUT(4), .DW(8), .ACC_W(32), .OUT_W(16), .SHIFT(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .relu_en(relu_en),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_idx(out_idx1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int a, input int d);
        w_wr_en = 1'b1;
        w_addr  = 6'(a);
        w_data  = 8'(d);
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic wr_b(input int a, input int d);
        b_wr_en = 1'b1;
        b_addr  = 2'(a);
        b_data  = 32'(d);
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic load_w_all(input int d);
        for (int a = 0; a < 36; a++) wr_w(a, d);
    endtask

    task automatic expect4(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        int   a[4];
        int   b[4];
        exp_t e;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < 4; k++) begin
            e.idx = 2'(k);
            e.data = 16'(a[k]);
            q0.push_back(e);
            e.data = 16'(b[k]);
            q1.push_back(e);
        end
        exp_dones++;
    endtask

    // xmode 0: x = 1..9, xmode 1: all x = 127. Optional weight write on the accept edge.
    task automatic send(input int xmode, input bit relu, input bit same_w,
                        input int sw_addr, input int sw_data);
        int n = 0;
        while (!in_ready0 && n < 100) begin
            tick();
            n++;
        end
        check("in_ready0_before_send", in_ready0, 1);
        check("in_ready1_before_send", in_ready1, 1);
        for (int k = 0; k < 9; k++) begin
            in_data[k*8 +: 8] = (xmode == 0) ? 8'(k + 1) : 8'd127;
        end
        relu_en  = relu;
        in_valid = 1'b1;
        if (same_w) begin
            w_wr_en = 1'b1;
            w_addr  = 6'(sw_addr);
            w_data  = 8'(sw_data);
        end
        tick();
        in_valid = 1'b0;
        w_wr_en  = 1'b0;
        relu_en  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done0 && n < 300) begin
            tick();
            n++;
        end
        check("done_seen", done0, 1);
    endtask

    // Scoreboard monitor: pops on every output handshake, checks latencies and done pulses.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid0 && out_ready) begin
                check("q0_nonempty", (q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("out0_idx", out_idx0, e.idx);
                    check("out0_data", $signed(out_data0), $signed(e.data));
                end
            end
            if (out_valid1 && out_ready) begin
                check("q1_nonempty", (q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("out1_idx", out_idx1, e.idx);
                    check("out1_data", $signed(out_data1), $signed(e.data));
                end
            end
            if (out_valid0 && first_pend) begin
                first_pend = 0;
                if (lat_on) check("first_valid_latency", cyc - acc_cyc, 10);
            end
            if (done0 || done1) check("done1_vs_done0", done1, done0);
            if (done0) begin
                check("done_expected", (exp_dones > 0), 1);
                if (exp_dones > 0) exp_dones--;
                if (lat_on) check("done_latency", cyc - acc_cyc, lat_done);
            end
            if (in_valid && in_ready0) begin
                acc_cyc    = cyc;
                first_pend = 1;
                lat_on     = chk_lat;
                lat_done   = exp_done_lat;
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
        b_wr_en = 1'b0; b_addr = '0; b_data = '0;
        in_valid = 1'b0; in_data = '0; relu_en = 1'b0; out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) tick();
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_data", out_data0, 0);
        check("rst_out_idx", out_idx0, 0);
        check("rst_busy", busy0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done", done0, 0);
        rst = 1'b0;
        tick();

        // Basic sums, then ReLU back-to-back
        load_w_all(1);
        wr_b(0, 0); wr_b(1, 10); wr_b(2, -100); wr_b(3, -50);
        chk_lat = 1; exp_done_lat = 41;
        expect4(45, 55, -55, -5, 11, 13, -14, -2);
        send(0, 0, 0, 0, 0);
        wait_done();
        expect4(45, 55, 0, 0, 11, 13, 0, 0);
        send(0, 1, 0, 0, 0);
        wait_done();

        // Backpressure: 5 stall cycles on idx 1
        exp_done_lat = 46;
        expect4(45, 55, -55, -5, 11, 13, -14, -2);
        send(0, 0, 0, 0, 0);
        n = 0;
        while (!(out_valid0 && out_idx0 == 2'd0) && n < 100) begin tick(); n++; end
        tick();
        out_ready = 1'b0;
        n = 0;
        while (!(out_valid0 && out_idx0 == 2'd1) && n < 100) begin tick(); n++; end
        check("bp_reached_idx1", out_idx0, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("bp_valid", out_valid0, 1);
            check("bp_data", $signed(out_data0), 55);
            check("bp_idx", out_idx0, 1);
            check("bp_no_done", done0, 0);
            if (k == 5) out_ready = 1'b1;
        end
        wait_done();

        // Reset at MAC cycle 4: partial vector dropped
        chk_lat = 0;
        send(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("busy_in_mac", busy0, 1);
        rst = 1'b1;
        tick();
        check("midrst_in_ready", in_ready0, 1);
        check("midrst_busy", busy0, 0);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_out_data", out_data0, 0);
        check("midrst_done", done0, 0);
        rst = 1'b0;
        repeat (15) tick();

        // Rerun basic; weight and bias writes during MAC must be ignored
        chk_lat = 1; exp_done_lat = 41;
        expect4(45, 55, -55, -5, 11, 13, -14, -2);
        send(0, 0, 0, 0, 0);
        wr_w(35, 50);
        wr_b(3, 1000);
        wait_done();

        // Weight write on the accept edge is visible: W[0]=3 adds 2 to neuron 0
        expect4(47, 55, -55, -5, 11, 13, -14, -2);
        send(0, 0, 1, 0, 3);
        wait_done();

        // Saturation, both polarities
        wr_b(0, 0); wr_b(1, 0); wr_b(2, 0); wr_b(3, 0);
        load_w_all(127);
        expect4(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        send(1, 0, 0, 0, 0);
        wait_done();
        load_w_all(-128);
        expect4(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        send(1, 0, 0, 0, 0);
        wait_done();

        repeat (5) tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("dones_balanced", exp_dones, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_seq.md
# fc_layer_seq

Parametrised, sequential fully-connected layer for the CNN core. It accepts one flattened feature vector of `N_IN` signed elements and computes `N_OUT` dot products against on-chip weights, one MAC per cycle. Each result gets a per-output bias, an arithmetic shift and optional ReLU, is saturated to `OUT_W`, and is streamed out under a valid/ready handshake. It sits after the last pooling stage and feeds the classifier/argmax stage.

## Interface
Parameters:
- `N_IN`, 9: input vector length (≥1).
- `N_OUT`, 4: number of output neurons (≥1).
- `DW`, 8: signed width of input elements and weights.
- `ACC_W`, 32: signed accumulator and bias width (≥ 2*DW + clog2(N_IN)).
- `OUT_W`, 16: signed output width (≤ ACC_W).
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `w_wr_en`  in  1  weight write strobe.
- `w_addr`  in  clog2(N_IN*N_OUT)  weight address = j*N_IN + i.
- `w_data`  in  DW  signed weight.
- `b_wr_en`  in  1  bias write strobe.
- `b_addr`  in  clog2(N_OUT) (min 1)  bias index j.
- `b_data`  in  ACC_W  signed bias.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_data`  in  N_IN*DW  element i at bits [i*DW +: DW], signed.
- `relu_en`  in  1  ReLU mode; sampled on input accept.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  OUT_W  signed result.
- `out_idx`  out  clog2(N_OUT) (min 1)  neuron index j of `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `in_data` and `relu_en`;
  - set j=0, i=0, acc=bias[j];
  - go to MAC.
- MAC: each cycle, acc += sext(x[i]*W[j*N_IN+i]) and i increments. The product is full 2*DW signed and is sign-extended to ACC_W. The sum wraps modulo 2^ACC_W. After the i=N_IN-1 term is added, go to OUT.
- OUT: the result is computed from the final acc:
  - r = acc >>> SHIFT;
  - if the latched relu_en is set and r<0, r=0;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- OUT drives `out_valid`=1 with `out_data`=r and `out_idx`=j. Both are held stable until `out_ready`.
- On the OUT handshake:
  - if j<N_OUT-1: j++, i=0, acc=bias[j+1], go to MAC;
  - else: pulse `done` next cycle and go to IDLE.
- Weight and bias writes are applied only while in IDLE. Writes in MAC/OUT are ignored.
- Writes with an out-of-range address are ignored.
- Weight and bias storage is not cleared by `rst`. Its contents are undefined until written.
- `in_valid` outside IDLE is ignored, because `in_ready`=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0; FSM in IDLE, acc=0.
- Reset mid-operation: state returns to IDLE next cycle. The partial vector is dropped. No `out_valid` or `done` is produced for it.
- Input accepted at edge T0:
  - MAC occupies cycles T0+1..T0+N_IN;
  - first `out_valid` is high at T0+N_IN+1.
- Each further output adds N_IN+1 cycles plus any stall cycles.
- With `out_ready` tied high, the last handshake occurs at T0+N_OUT*(N_IN+1).
- `done`=1 for exactly one cycle, the cycle after the last handshake. `in_ready` returns to 1 in that same cycle.
- Back-to-back: a new vector may be accepted in the `done` cycle.
- Backpressure: `out_ready`=0 stalls only the OUT state. No MAC proceeds while stalled.
- A weight write at the same edge as the input accept takes effect, i.e. it is visible to the MAC.

## Test plan
Defaults: N_IN=9, N_OUT=4, DW=8, OUT_W=16, SHIFT=0 unless stated.
- Basic sums: all W=1, x=1..9, bias {0,10,-100,-50}, relu_en=0, out_ready=1.
  - Required: out (idx,data) = (0,45),(1,55),(2,-55),(3,-5).
  - First valid 10 cycles after accept; `done` 41 cycles after accept.
- ReLU: same stimulus with relu_en=1 -> 45, 55, 0, 0.
- Saturation: all x=127, all W=127, bias 0 -> 32767 ×4 (raw 145161).
  - Then all W=-128 -> -32768 ×4 (raw -146304).
- Shift: SHIFT=2, basic stimulus -> 11, 13, -14, -2.
- Backpressure: hold out_ready=0 for 5 cycles at idx=1.
  - Required: out_data=55 and out_idx=1 stable throughout; no `done` early; total latency grows by 5.
- Reset mid-MAC, then writes while busy:
  - assert rst at MAC cycle 4 -> outputs at reset values next cycle, no `done`;
  - re-run basic stimulus -> identical results;
  - a weight write issued during MAC is ignored (results unchanged).
